// File: rtl/predictor_pkg.sv
// Shared definitions for the hybrid branch predictor.
// Holds the sequencer state type, the default counter width and the
// saturating counter step used by every pattern and chooser table.
package predictor_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_CTR_BITS = 2;
  // Widest counter the shared update function handles.
  localparam int unsigned MAX_CTR_BITS     = 16;

  // One saturating step of a bits-wide counter: up increments, otherwise decrements.
  function automatic logic [MAX_CTR_BITS-1:0] sat_update(
    input logic [MAX_CTR_BITS-1:0] ctr,
    input logic                    up,
    input int unsigned             bits
  );
    logic [MAX_CTR_BITS-1:0] top;
    logic [MAX_CTR_BITS-1:0] res;
    top = MAX_CTR_BITS'((32'(1) << bits) - 32'(1));
    res = ctr;
    if (up) begin
      if (ctr != top) res = ctr + MAX_CTR_BITS'(1);
    end else begin
      if (ctr != '0) res = ctr - MAX_CTR_BITS'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_ctr_table.sv
// Table of saturating counters with one combinational read port, one
// read-modify-write update port and an init write port used by the sweep.
// Ports:
//   clock              system clock
//   rd_idx / rd_ctr_c  lookup index and current counter value (combinational)
//   upd_en/idx/up      counter update: step up (taken/local) or down
//   init_en/init_idx   write the weakly-taken init value; wins over update
module sat_ctr_table
  import predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = 8,
  parameter int unsigned CTR_BITS = DEFAULT_CTR_BITS
) (
  input  logic                clock,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr_c,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_up,
  input  logic                init_en,
  input  logic [IDX_BITS-1:0] init_idx
);

  localparam int unsigned DEPTH = 32'(1) << IDX_BITS;
  localparam logic [CTR_BITS-1:0] INIT_VAL = {1'b1, {(CTR_BITS-1){1'b0}}};

  logic [CTR_BITS-1:0] mem [DEPTH];

  // Reads see the pre-update value; writes land at the edge.
  assign rd_ctr_c = mem[rd_idx];

  // Storage is intentionally unreset: the init sweep clears it.
  always_ff @(posedge clock) begin
    if (init_en) begin
      mem[init_idx] <= INIT_VAL;
    end else if (upd_en) begin
      mem[upd_idx] <= CTR_BITS'(sat_update(MAX_CTR_BITS'(mem[upd_idx]), upd_up, CTR_BITS));
    end
  end

endmodule

// File: rtl/hybrid_predictor.sv
// Tournament branch predictor: per-PC local history + local pattern table,
// gshare on a speculative global history, and a per-PC chooser.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   pred_req, pred_PC            lookup request and branch PC
//   pred_taken/_local/_global    final, local and gshare predictions
//   pred_ghr                     global history used for this lookup
//   ready                        tables initialised, lookups/updates accepted
//   res_*                        resolved branch: PC, history snapshot,
//                                outcome, component predictions, mispredict
module hybrid_predictor
  import predictor_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LHT_IDX_BITS = 8,
  parameter int unsigned LH_BITS      = 8,
  parameter int unsigned GHR_BITS     = 8,
  parameter int unsigned CH_IDX_BITS  = 8,
  parameter int unsigned CTR_BITS     = DEFAULT_CTR_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pred_req,
  input  logic [XLEN-1:0]     pred_PC,
  output logic                pred_taken,
  output logic                pred_local_taken,
  output logic                pred_global_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  output logic                ready,
  input  logic                res_valid,
  input  logic [XLEN-1:0]     res_PC,
  input  logic [GHR_BITS-1:0] res_ghr,
  input  logic                res_taken,
  input  logic                res_local_taken,
  input  logic                res_global_taken,
  input  logic                res_mispredict
);

  localparam int unsigned MAXB_A    = (LHT_IDX_BITS > LH_BITS) ? LHT_IDX_BITS : LH_BITS;
  localparam int unsigned MAXB_B    = (GHR_BITS > CH_IDX_BITS) ? GHR_BITS : CH_IDX_BITS;
  localparam int unsigned MAXB      = (MAXB_A > MAXB_B) ? MAXB_A : MAXB_B;
  localparam int unsigned LHT_DEPTH = 32'(1) << LHT_IDX_BITS;
  localparam logic [MAXB-1:0] IDX_LAST = '1;

  state_t              state, state_n;
  logic [MAXB-1:0]     idx, idx_n;
  logic [GHR_BITS-1:0] ghr, ghr_n;

  logic [LH_BITS-1:0]  lht [LHT_DEPTH];
  logic [LH_BITS-1:0]  pred_hist, res_hist;
  logic [LHT_IDX_BITS-1:0] pred_lidx, res_lidx;
  logic [CTR_BITS-1:0] lpht_ctr, gsh_ctr, ch_ctr;
  logic                local_raw, global_raw, final_raw;
  logic                init_en, upd_en;
  logic                unused_pc;

  assign unused_pc = ^{pred_PC, res_PC};

  assign ready   = (state == RUN);
  assign init_en = (state == INIT);
  // Resolutions arriving before the sweep finishes are dropped.
  assign upd_en  = res_valid & ready;

  assign pred_lidx = pred_PC[LHT_IDX_BITS+1:2];
  assign res_lidx  = res_PC[LHT_IDX_BITS+1:2];
  assign pred_hist = lht[pred_lidx];
  assign res_hist  = lht[res_lidx];

  sat_ctr_table #(.IDX_BITS(LH_BITS), .CTR_BITS(CTR_BITS)) u_lpht (
    .clock    (clock),
    .rd_idx   (pred_hist),
    .rd_ctr_c (lpht_ctr),
    .upd_en   (upd_en),
    .upd_idx  (res_hist),
    .upd_up   (res_taken),
    .init_en  (init_en),
    .init_idx (idx[LH_BITS-1:0])
  );

  sat_ctr_table #(.IDX_BITS(GHR_BITS), .CTR_BITS(CTR_BITS)) u_gshare (
    .clock    (clock),
    .rd_idx   (ghr ^ pred_PC[GHR_BITS+1:2]),
    .rd_ctr_c (gsh_ctr),
    .upd_en   (upd_en),
    .upd_idx  (res_ghr ^ res_PC[GHR_BITS+1:2]),
    .upd_up   (res_taken),
    .init_en  (init_en),
    .init_idx (idx[GHR_BITS-1:0])
  );

  // Chooser trains only when the components disagreed; up means "trust local".
  sat_ctr_table #(.IDX_BITS(CH_IDX_BITS), .CTR_BITS(CTR_BITS)) u_chooser (
    .clock    (clock),
    .rd_idx   (pred_PC[CH_IDX_BITS+1:2]),
    .rd_ctr_c (ch_ctr),
    .upd_en   (upd_en & (res_local_taken ^ res_global_taken)),
    .upd_idx  (res_PC[CH_IDX_BITS+1:2]),
    .upd_up   (res_local_taken == res_taken),
    .init_en  (init_en),
    .init_idx (idx[CH_IDX_BITS-1:0])
  );

  assign local_raw  = lpht_ctr[CTR_BITS-1];
  assign global_raw = gsh_ctr[CTR_BITS-1];
  assign final_raw  = ch_ctr[CTR_BITS-1] ? local_raw : global_raw;

  assign pred_local_taken  = ready & local_raw;
  assign pred_global_taken = ready & global_raw;
  assign pred_taken        = ready & final_raw;
  assign pred_ghr          = ready ? ghr : '0;

  // Local history table: cleared by the sweep, shifts in outcomes at the LSB.
  always_ff @(posedge clock) begin
    if (init_en) begin
      lht[idx[LHT_IDX_BITS-1:0]] <= '0;
    end else if (upd_en) begin
      lht[res_lidx] <= {res_hist[LH_BITS-2:0], res_taken};
    end
  end

  // Sequencer, sweep index and global history registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      idx   <= '0;
      ghr   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      ghr   <= ghr_n;
    end
  end

  // Next state: sweep every index once, then run; recovery beats speculation.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    ghr_n   = ghr;
    case (state)
      INIT: begin
        idx_n = idx + MAXB'(1);
        ghr_n = '0;
        if (idx == IDX_LAST) state_n = RUN;
      end
      RUN: begin
        if (res_valid && res_mispredict) begin
          ghr_n = {res_ghr[GHR_BITS-2:0], res_taken};
        end else if (pred_req) begin
          ghr_n = {ghr[GHR_BITS-2:0], final_raw};
        end
      end
      default: state_n = INIT;
    endcase
  end

endmodule

// File: tb/tb_hybrid_predictor.sv
// Scoreboarded random/directed bench for hybrid_predictor against an
// array-based model of the prediction rules.
module tb_hybrid_predictor;

  localparam int FX_NONE   = -1;
  localparam int FX_LOCAL  = 0;
  localparam int FX_GLOBAL = 1;
  localparam int FX_GHR    = 2;
  localparam int FX_TAKEN  = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        pred_req, res_valid, res_taken, res_local_taken, res_global_taken, res_mispredict;
  logic [31:0] pred_pc, res_pc;
  logic [7:0]  res_ghr;
  logic        pred_taken, pred_local_taken, pred_global_taken, ready;
  logic [7:0]  pred_ghr;

  logic        pred_req3, res_valid3, res_taken3, res_local3, res_global3, res_mis3;
  logic [31:0] pred_pc3, res_pc3;
  logic [7:0]  res_ghr3;
  logic        pred_taken3, pred_local3, pred_global3, ready3;
  logic [7:0]  pred_ghr3;

  hybrid_predictor u_dut (
    .clock(clock), .reset(reset), .pred_req(pred_req), .pred_PC(pred_pc),
    .pred_taken(pred_taken), .pred_local_taken(pred_local_taken),
    .pred_global_taken(pred_global_taken), .pred_ghr(pred_ghr), .ready(ready),
    .res_valid(res_valid), .res_PC(res_pc), .res_ghr(res_ghr), .res_taken(res_taken),
    .res_local_taken(res_local_taken), .res_global_taken(res_global_taken),
    .res_mispredict(res_mispredict)
  );

  hybrid_predictor #(.CTR_BITS(3)) u_dut3 (
    .clock(clock), .reset(reset), .pred_req(pred_req3), .pred_PC(pred_pc3),
    .pred_taken(pred_taken3), .pred_local_taken(pred_local3),
    .pred_global_taken(pred_global3), .pred_ghr(pred_ghr3), .ready(ready3),
    .res_valid(res_valid3), .res_PC(res_pc3), .res_ghr(res_ghr3), .res_taken(res_taken3),
    .res_local_taken(res_local3), .res_global_taken(res_global3),
    .res_mispredict(res_mis3)
  );

  typedef struct {
    int inst;
    int rdy, tk, loc, glb, ghr;
    int fx_what, fx_val;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model state
  int m_lht[256], m_lpht[256], m_gsh[256], m_ch[256];
  int m_ghr, m_cnt, m_c3;
  int last_loc, last_glb, last_fin, last_ghr;

  function automatic int sat(input int v, input int up, input int vmax);
    if (up != 0) return (v < vmax) ? v + 1 : vmax;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic idle();
    pred_req = 0; pred_pc = '0; res_valid = 0; res_pc = '0; res_ghr = '0;
    res_taken = 0; res_local_taken = 0; res_global_taken = 0; res_mispredict = 0;
    pred_req3 = 0; pred_pc3 = '0; res_valid3 = 0; res_pc3 = '0; res_ghr3 = '0;
    res_taken3 = 0; res_local3 = 0; res_global3 = 0; res_mis3 = 0;
  endtask

  // One clock of stimulus: predict from the model, queue the expectation, advance the model.
  task automatic tick(input int inst, input int fx_what, input int fx_val);
    exp_t e;
    int li, gi, ri, h, rdy;
    if (m_cnt == 256) begin
      for (int i = 0; i < 256; i++) begin
        m_lht[i] = 0; m_lpht[i] = 2; m_gsh[i] = 2; m_ch[i] = 2;
      end
      m_c3 = 4;
    end
    rdy = (m_cnt >= 256) ? 1 : 0;
    li = int'((pred_pc >> 2) & 32'hFF);
    gi = li ^ m_ghr;
    last_loc = (rdy != 0 && m_lpht[m_lht[li]] >= 2) ? 1 : 0;
    last_glb = (rdy != 0 && m_gsh[gi] >= 2) ? 1 : 0;
    last_fin = (rdy == 0) ? 0 : ((m_ch[li] >= 2) ? last_loc : last_glb);
    last_ghr = (rdy != 0) ? m_ghr : 0;
    e.inst = inst; e.rdy = rdy; e.fx_what = fx_what; e.fx_val = fx_val;
    if (inst == 0) begin
      e.tk = last_fin; e.loc = last_loc; e.glb = last_glb; e.ghr = last_ghr;
    end else begin
      e.tk = 0; e.loc = 0; e.glb = (rdy != 0 && m_c3 >= 4) ? 1 : 0; e.ghr = 0;
    end
    exp_q.push_back(e);
    if (rdy != 0) begin
      if (res_valid) begin
        ri = int'((res_pc >> 2) & 32'hFF);
        h  = m_lht[ri];
        m_lpht[h] = sat(m_lpht[h], int'(res_taken), 3);
        m_gsh[ri ^ int'(res_ghr)] = sat(m_gsh[ri ^ int'(res_ghr)], int'(res_taken), 3);
        if (res_local_taken != res_global_taken)
          m_ch[ri] = sat(m_ch[ri], (res_local_taken == res_taken) ? 1 : 0, 3);
        m_lht[ri] = ((h << 1) | int'(res_taken)) & 255;
      end
      if (res_valid && res_mispredict) m_ghr = ((int'(res_ghr) << 1) | int'(res_taken)) & 255;
      else if (pred_req)               m_ghr = ((m_ghr << 1) | last_fin) & 255;
      if (res_valid3) m_c3 = sat(m_c3, int'(res_taken3), 7);
    end
    m_cnt++;
    @(posedge clock); #1;
  endtask

  task automatic do_reset(input int n);
    idle();
    reset = 1;
    repeat (n) begin @(posedge clock); #1; end
    reset = 0;
    m_cnt = 0;
    m_ghr = 0;
  endtask

  task automatic rand_tick();
    pred_req = 1'($urandom_range(0, 1));
    pred_pc = 32'($urandom_range(0, 1023)) << 2;
    res_valid = 1'($urandom_range(0, 1));
    res_pc = 32'($urandom_range(0, 1023)) << 2;
    res_ghr = 8'($urandom_range(0, 255));
    res_taken = 1'($urandom_range(0, 1));
    res_local_taken = 1'($urandom_range(0, 1));
    res_global_taken = 1'($urandom_range(0, 1));
    res_mispredict = ($urandom_range(0, 3) == 0);
    tick(0, FX_NONE, 0);
  endtask

  // Monitor: pops one expectation per cycle, compares away from the active edge.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      int a_loc, a_glb, a_tk, a_ghr;
      e = exp_q.pop_front();
      if (e.inst == 0) begin
        a_loc = int'(pred_local_taken); a_glb = int'(pred_global_taken);
        a_tk = int'(pred_taken); a_ghr = int'(pred_ghr);
        check("ready", int'(ready), e.rdy);
        check("pred_taken", a_tk, e.tk);
        check("pred_local_taken", a_loc, e.loc);
        check("pred_global_taken", a_glb, e.glb);
        check("pred_ghr", a_ghr, e.ghr);
      end else begin
        a_loc = int'(pred_local3); a_glb = int'(pred_global3);
        a_tk = int'(pred_taken3); a_ghr = int'(pred_ghr3);
        check("ready_ctr3", int'(ready3), e.rdy);
        check("pred_global_ctr3", a_glb, e.glb);
        check("pred_ghr_ctr3", a_ghr, e.ghr);
      end
      case (e.fx_what)
        FX_LOCAL:  check("fixed_local", a_loc, e.fx_val);
        FX_GLOBAL: check("fixed_global", a_glb, e.fx_val);
        FX_GHR:    check("fixed_ghr", a_ghr, e.fx_val);
        FX_TAKEN:  check("fixed_taken", a_tk, e.fx_val);
        default: ;
      endcase
    end
  end

  initial begin
    int outcome;
    idle();
    m_ghr = 0; m_cnt = 0; m_c3 = 0;
    do_reset(3);

    // Sweep: ready low for exactly 256 cycles.
    repeat (256) tick(0, FX_NONE, 0);

    // First lookups after init.
    pred_pc = 32'($urandom_range(0, 1023)) << 2;
    tick(0, FX_TAKEN, 1);
    tick(0, FX_GHR, 0);

    // 3-bit counters: 4 -> saturate at 7 -> back down to 2.
    pred_pc3 = 32'h300; res_pc3 = 32'h300; res_ghr3 = '0;
    res_local3 = 1; res_global3 = 1; res_valid3 = 1; res_taken3 = 1;
    repeat (5) tick(1, FX_NONE, 0);
    res_taken3 = 0;
    tick(1, FX_GLOBAL, 1);
    repeat (3) tick(1, FX_NONE, 0);
    tick(1, FX_GLOBAL, 0);
    res_valid3 = 0;
    tick(1, FX_GLOBAL, 0);
    idle();

    // Gshare counter at 0x40 driven to zero.
    res_valid = 1; res_pc = 32'h100; res_ghr = '0; res_taken = 0;
    res_local_taken = 1; res_global_taken = 1; res_mispredict = 0;
    repeat (3) tick(0, FX_NONE, 0);
    idle();
    pred_pc = 32'h100;
    tick(0, FX_GLOBAL, 0);

    // Speculative history then recovery overriding a same-cycle request.
    for (int k = 1; k <= 4; k++) begin
      pred_req = 1; pred_pc = 32'h1000 + 32'(k * 4);
      tick(0, FX_NONE, 0);
    end
    res_valid = 1; res_pc = 32'h1000; res_ghr = 8'h01; res_taken = 0;
    res_local_taken = 0; res_global_taken = 0; res_mispredict = 1;
    tick(0, FX_NONE, 0);
    idle();
    tick(0, FX_GHR, 2);

    // Local periodic pattern T,T,N at PC 0x200.
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 3; k++) begin
        outcome = (k != 2) ? 1 : 0;
        idle();
        pred_req = 1; pred_pc = 32'h200;
        tick(0, (it >= 10) ? FX_LOCAL : FX_NONE, outcome);
        idle();
        res_valid = 1; res_pc = 32'h200; res_ghr = 8'(last_ghr);
        res_taken = 1'(outcome); res_local_taken = 1'(last_loc);
        res_global_taken = 1'(last_glb); res_mispredict = (last_fin != outcome);
        tick(0, FX_NONE, 0);
      end
    end
    idle();

    // Random traffic dirties every table.
    repeat (1500) rand_tick();

    // Reset from RUN, then again mid-sweep; traffic during the sweep must be ignored.
    do_reset(1);
    repeat (100) rand_tick();
    do_reset(1);
    repeat (256) rand_tick();

    // Every entry reads its init value.
    idle();
    for (int i = 0; i < 256; i++) begin
      pred_pc = 32'(i) << 2;
      tick(0, FX_TAKEN, 1);
    end

    @(negedge clock); #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
